// File: rtl/fetch_buffer_if.sv
// Fetch/decode boundary bundle for the fetch buffer.
// master = the side that drives fetch data and decode control (fetch unit + decode),
// slave  = the buffer itself.
interface fetch_buffer_if;
  // fetch side
  logic        fetch_vld;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_inst;
  logic [1:0]  fetch_except;
  logic [31:0] fetch_target;
  logic        fetch_ready;
  logic [4:0]  buf_count;
  // decode side
  logic        instruction_vld;
  logic [31:0] instruction;
  logic [31:0] PC_stage2;
  logic [1:0]  except_stage2;
  logic [31:0] instruction_target_stage2;
  logic        hold_stage3;
  logic        flush_stage3;

  modport master (
    output fetch_vld, fetch_pc, fetch_inst, fetch_except, fetch_target,
    output hold_stage3, flush_stage3,
    input  fetch_ready, buf_count,
    input  instruction_vld, instruction, PC_stage2, except_stage2,
    input  instruction_target_stage2
  );

  modport slave (
    input  fetch_vld, fetch_pc, fetch_inst, fetch_except, fetch_target,
    input  hold_stage3, flush_stage3,
    output fetch_ready, buf_count,
    output instruction_vld, instruction, PC_stage2, except_stage2,
    output instruction_target_stage2
  );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: circular FIFO of {pc, inst, except, target} between
// fetch and decode. An enqueued fetch exception locks the buffer against further
// enqueues until decode flushes the pipeline. Head outputs are combinational from
// the stored head entry, so a new instruction is visible one cycle after enqueue.
module fetch_buffer #(
  parameter int DEPTH = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  fetch_buffer_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_wptr;
  logic [CW-1:0] r_count;

  // payload storage is intentionally left unreset
  logic [31:0]   r_pc_mem     [DEPTH];
  logic [31:0]   r_inst_mem   [DEPTH];
  logic [1:0]    r_exc_mem    [DEPTH];
  logic [31:0]   r_tgt_mem    [DEPTH];

  logic          w_ready;
  logic          w_vld;
  logic          w_enq;
  logic          w_deq;

  // Flush wins over both enqueue and dequeue; dequeue needs a valid head.
  assign w_vld = (r_count != {CW{1'b0}});
  assign w_enq = bus.fetch_vld && w_ready && !bus.flush_stage3;
  assign w_deq = w_vld && !bus.hold_stage3 && !bus.flush_stage3;

  // Lock state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Lock next state: any excepting enqueue locks, only a flush unlocks.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (bus.flush_stage3) begin
          w_state_nxt = ST_RUN;
        end else if (w_enq && (bus.fetch_except != 2'b00)) begin
          w_state_nxt = ST_LOCKED;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_LOCKED: begin
        if (bus.flush_stage3) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_LOCKED;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Lock output: ready only when running, not full and not flushing.
  always_comb begin
    w_ready = 1'b0;
    if ((r_state == ST_RUN) && (r_count < CW'(DEPTH)) && !bus.flush_stage3) begin
      w_ready = 1'b1;
    end else begin
      w_ready = 1'b0;
    end
  end

  // Pointer and occupancy bookkeeping; flush returns everything to empty.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rptr  <= {PW{1'b0}};
      r_wptr  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
    end else if (bus.flush_stage3) begin
      r_rptr  <= {PW{1'b0}};
      r_wptr  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_enq) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_deq) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload write at the write pointer on every accepted enqueue.
  always_ff @(posedge i_clk) begin
    if (w_enq) begin
      r_pc_mem[r_wptr]   <= bus.fetch_pc;
      r_inst_mem[r_wptr] <= bus.fetch_inst;
      r_exc_mem[r_wptr]  <= bus.fetch_except;
      r_tgt_mem[r_wptr]  <= bus.fetch_target;
    end
  end

  assign bus.fetch_ready               = w_ready;
  assign bus.buf_count                 = 5'(r_count);
  assign bus.instruction_vld           = w_vld;
  assign bus.instruction               = r_inst_mem[r_rptr];
  assign bus.PC_stage2                 = r_pc_mem[r_rptr];
  assign bus.except_stage2             = r_exc_mem[r_rptr];
  assign bus.instruction_target_stage2 = r_tgt_mem[r_rptr];

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer (DEPTH = 8).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
module tb_fetch_buffer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  fetch_buffer_if u_if ();

  fetch_buffer #(.DEPTH(8)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [31:0] pc, input logic [1:0] exc);
    u_if.fetch_vld    = vld;
    u_if.fetch_pc     = pc;
    u_if.fetch_inst   = pc ^ 32'h5A5A_0000;
    u_if.fetch_except = exc;
    u_if.fetch_target = pc + 32'h0000_0100;
  endtask

  task automatic head_chk(input string tag, input logic [31:0] pc, input logic [1:0] exc, input int cnt);
    chk({tag, "_vld"}, {31'd0, u_if.instruction_vld}, 32'd1);
    chk({tag, "_pc"}, u_if.PC_stage2, pc);
    chk({tag, "_inst"}, u_if.instruction, pc ^ 32'h5A5A_0000);
    chk({tag, "_tgt"}, u_if.instruction_target_stage2, pc + 32'h0000_0100);
    chk({tag, "_exc"}, {30'd0, u_if.except_stage2}, {30'd0, exc});
    chk({tag, "_cnt"}, {27'd0, u_if.buf_count}, cnt);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    u_if.hold_stage3  = 1'b0;
    u_if.flush_stage3 = 1'b0;
    drive(1'b0, 32'd0, 2'b00);

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_cnt", {27'd0, u_if.buf_count}, 32'd0);
    chk("rst_vld", {31'd0, u_if.instruction_vld}, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, u_if.fetch_ready}, 32'd1);
    tick();

    // streaming: three instructions, no hold, one-cycle latency
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(1'b1, 32'h1C00_0000 + 32'(4 * i), 2'b00);
      else       drive(1'b0, 32'd0, 2'b00);
      @(negedge clk);
      if (i == 0) chk("stream_nobypass", {31'd0, u_if.instruction_vld}, 32'd0);
      if (i >= 1 && i <= 3) head_chk("stream", 32'h1C00_0000 + 32'(4 * (i - 1)), 2'b00, 1);
      if (i == 4) begin
        chk("stream_end_cnt", {27'd0, u_if.buf_count}, 32'd0);
        chk("stream_end_vld", {31'd0, u_if.instruction_vld}, 32'd0);
      end
      tick();
    end

    // fill under hold
    u_if.hold_stage3 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h2000_0000 + 32'(4 * i), 2'b00);
      @(negedge clk);
      chk("fill_cnt", {27'd0, u_if.buf_count}, 32'(i));
      chk("fill_ready", {31'd0, u_if.fetch_ready}, 32'd1);
      tick();
    end
    // 9th fetch is dropped
    drive(1'b1, 32'h0000_DEAD, 2'b00);
    @(negedge clk);
    chk("full_cnt", {27'd0, u_if.buf_count}, 32'd8);
    chk("full_ready", {31'd0, u_if.fetch_ready}, 32'd0);
    head_chk("full_head_stable", 32'h2000_0000, 2'b00, 8);
    tick();
    // full with simultaneous dequeue and fetch: no enqueue
    u_if.hold_stage3 = 1'b0;
    drive(1'b1, 32'h0000_BAD0, 2'b00);
    @(negedge clk);
    chk("fulldeq_ready", {31'd0, u_if.fetch_ready}, 32'd0);
    head_chk("drain", 32'h2000_0000, 2'b00, 8);
    tick();
    drive(1'b0, 32'd0, 2'b00);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      head_chk("drain", 32'h2000_0000 + 32'(4 * i), 2'b00, 8 - i);
      tick();
    end
    @(negedge clk);
    chk("drain_cnt", {27'd0, u_if.buf_count}, 32'd0);
    chk("drain_vld", {31'd0, u_if.instruction_vld}, 32'd0);

    // exception lock
    u_if.hold_stage3 = 1'b1;
    drive(1'b1, 32'h3000_0000, 2'b00);
    tick();
    drive(1'b1, 32'h3000_0004, 2'b01);
    tick();
    drive(1'b1, 32'h3000_0008, 2'b00);
    @(negedge clk);
    chk("lock_ready", {31'd0, u_if.fetch_ready}, 32'd0);
    chk("lock_cnt", {27'd0, u_if.buf_count}, 32'd2);
    tick();
    u_if.hold_stage3 = 1'b0;
    drive(1'b0, 32'd0, 2'b00);
    @(negedge clk);
    head_chk("lock_h0", 32'h3000_0000, 2'b00, 2);
    tick();
    @(negedge clk);
    head_chk("lock_h1", 32'h3000_0004, 2'b01, 1);
    tick();
    drive(1'b1, 32'h3000_000C, 2'b00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("locked_ready", {31'd0, u_if.fetch_ready}, 32'd0);
      chk("locked_cnt", {27'd0, u_if.buf_count}, 32'd0);
      tick();
    end
    drive(1'b0, 32'd0, 2'b00);
    u_if.flush_stage3 = 1'b1;
    @(negedge clk);
    chk("flush_ready_low", {31'd0, u_if.fetch_ready}, 32'd0);
    tick();
    u_if.flush_stage3 = 1'b0;
    @(negedge clk);
    chk("unlock_ready", {31'd0, u_if.fetch_ready}, 32'd1);

    // wrap the pointers, then flush with a concurrent fetch
    u_if.hold_stage3 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h4000_0000 + 32'(4 * i), 2'b00);
      tick();
    end
    u_if.hold_stage3 = 1'b0;
    drive(1'b0, 32'd0, 2'b00);
    for (int i = 0; i < 4; i++) tick();
    u_if.hold_stage3 = 1'b1;
    for (int i = 6; i < 9; i++) begin
      drive(1'b1, 32'h4000_0000 + 32'(4 * i), 2'b00);
      tick();
    end
    @(negedge clk);
    head_chk("wrap_head", 32'h4000_0010, 2'b00, 5);
    tick();
    u_if.hold_stage3  = 1'b0;
    u_if.flush_stage3 = 1'b1;
    drive(1'b1, 32'h4000_0100, 2'b00);
    tick();
    u_if.flush_stage3 = 1'b0;
    drive(1'b0, 32'd0, 2'b00);
    @(negedge clk);
    chk("wflush_cnt", {27'd0, u_if.buf_count}, 32'd0);
    chk("wflush_vld", {31'd0, u_if.instruction_vld}, 32'd0);
    chk("wflush_ready", {31'd0, u_if.fetch_ready}, 32'd1);
    tick();
    drive(1'b1, 32'h4000_0200, 2'b00);
    tick();
    drive(1'b0, 32'd0, 2'b00);
    @(negedge clk);
    head_chk("post_flush", 32'h4000_0200, 2'b00, 1);
    tick();

    // asynchronous reset while locked with 3 entries
    u_if.hold_stage3 = 1'b1;
    drive(1'b1, 32'h5000_0000, 2'b00);
    tick();
    drive(1'b1, 32'h5000_0004, 2'b00);
    tick();
    drive(1'b1, 32'h5000_0008, 2'b10);
    tick();
    drive(1'b0, 32'd0, 2'b00);
    @(negedge clk);
    chk("pre_arst_cnt", {27'd0, u_if.buf_count}, 32'd3);
    chk("pre_arst_ready", {31'd0, u_if.fetch_ready}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_cnt", {27'd0, u_if.buf_count}, 32'd0);
    chk("arst_vld", {31'd0, u_if.instruction_vld}, 32'd0);
    chk("arst_ready", {31'd0, u_if.fetch_ready}, 32'd1);
    tick();
    rst = 1'b0;
    u_if.hold_stage3 = 1'b0;
    drive(1'b1, 32'h6000_0000, 2'b00);
    @(negedge clk);
    chk("after_arst_ready", {31'd0, u_if.fetch_ready}, 32'd1);
    tick();
    drive(1'b0, 32'd0, 2'b00);
    @(negedge clk);
    head_chk("after_arst", 32'h6000_0000, 2'b00, 1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter: DEPTH, 8, number of instruction entries; power of two, 2..16.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 fetch_vld  input  1  fetch unit presents one instruction this cycle.
REQ-005 fetch_pc  input  32  PC of the presented instruction.
REQ-006 fetch_inst  input  32  instruction word.
REQ-007 fetch_except  input  2  fetch exception code; 2'b00 means no exception.
REQ-008 fetch_target  input  32  predicted next PC for this instruction.
REQ-009 fetch_ready  output  1  buffer accepts an enqueue this cycle.
REQ-010 buf_count  output  5  current occupancy, 0..DEPTH.
REQ-011 instruction_vld  output  1  head entry valid toward decode.
REQ-012 instruction  output  32  head instruction word.
REQ-013 PC_stage2  output  32  head PC.
REQ-014 except_stage2  output  2  head exception code.
REQ-015 instruction_target_stage2  output  32  head predicted target.
REQ-016 hold_stage3  input  1  decode stalled; head is not consumed.
REQ-017 flush_stage3  input  1  pipeline flush; discard all buffered state.

Function
REQ-018 Storage: circular FIFO of DEPTH entries {pc, inst, except, target}; read pointer, write pointer and count of log2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
REQ-019 Enqueue: occurs when fetch_vld && fetch_ready && !flush_stage3; the entry is written at the write pointer and the write pointer advances.
REQ-020 Dequeue: occurs when instruction_vld && !hold_stage3 && !flush_stage3; the read pointer advances.
REQ-021 Decode-side outputs are driven combinationally from the head entry; instruction_vld = (count != 0).
REQ-022 Latency: an instruction enqueued in cycle N appears on the head outputs in cycle N+1 when the buffer was empty; there is no same-cycle bypass.
REQ-023 Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
REQ-024 Full: fetch_ready = 0 when count == DEPTH, even if a dequeue occurs in the same cycle; no overwrite of entries ever occurs.
REQ-025 Empty: a dequeue is impossible when count == 0; the payload outputs hold their last-driven value and are don't-care.
REQ-026 When instruction_vld = 1 and hold_stage3 = 1, all head outputs remain stable.
REQ-027 Lock state machine has two states, RUN and LOCKED; the reset state is RUN.
REQ-028 RUN -> LOCKED on any enqueue with fetch_except != 0; the excepting entry itself is stored normally.
REQ-029 While in LOCKED, fetch_ready = 0.
REQ-030 LOCKED -> RUN only on flush_stage3.
REQ-031 fetch_ready = (state == RUN) && (count < DEPTH) && !flush_stage3.
REQ-032 Flush: in the cycle after flush_stage3 = 1, count = 0, both pointers = 0 and state = RUN; any enqueue or dequeue in the flush cycle is ignored.
REQ-033 flush_stage3 has priority over hold_stage3 and fetch_vld.
REQ-034 buf_count reflects registered occupancy, not the same-cycle enqueue or dequeue.

Reset
REQ-035 While rst = 1, regardless of clk: count = 0, pointers = 0, state = RUN, instruction_vld = 0, buf_count = 0.
REQ-036 Entry payload storage is not reset; fetch_ready = 1 in the first cycle after rst deasserts.
REQ-037 Asserting rst mid-operation discards all entries and the LOCKED state immediately.

Verification
REQ-038 Enqueue pc=0x1C000000/0x1C000004/0x1C000008 with hold_stage3 = 0 -> decode sees them in order starting one cycle later, and buf_count returns to 0.
REQ-039 hold_stage3 = 1, enqueue 8 entries -> buf_count = 8, fetch_ready = 0, a 9th fetch_vld is dropped; release the hold -> 8 entries drain in order.
REQ-040 Full buffer with simultaneous dequeue and fetch_vld -> no enqueue occurs and the next buf_count = 7.
REQ-041 Enqueue an entry with fetch_except = 2'b01 -> fetch_ready = 0 the next cycle, the entry reaches decode with except_stage2 = 2'b01, and the buffer stays locked until flush_stage3.
REQ-042 With 5 entries buffered and the pointers wrapped, pulse flush_stage3 together with fetch_vld -> next cycle count = 0, instruction_vld = 0, fetch_ready = 1.
REQ-043 Assert rst asynchronously between clock edges while LOCKED with 3 entries -> outputs clear immediately with no clock edge needed.
